// File: rtl/core_pkg.sv
// core_pkg -- definitions shared by the decode and execute stages.
//   XLEN       : default datapath width
//   OPC_OP     : register-register ALU opcode
//   OPC_OP_IMM : register-immediate ALU opcode
//   dec_t      : width-independent decoded-instruction fields
//   decode()   : instruction word -> dec_t
package core_pkg;
  localparam int XLEN = 64;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  typedef struct packed {
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rd;
    logic       rd_we;
    logic       illegal;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] instr);
    dec_t d;
    logic known;
    d.opcode  = instr[6:0];
    d.rd      = instr[11:7];
    d.funct3  = instr[14:12];
    d.funct7  = instr[31:25];
    known     = (instr[6:0] == OPC_OP) || (instr[6:0] == OPC_OP_IMM);
    d.illegal = !known;
    // Writes to x0 are pointless; suppress them here so execute need not.
    d.rd_we   = known && (instr[11:7] != 5'd0);
    return d;
  endfunction
endpackage

// File: rtl/id_stage_if.sv
// id_stage_if -- fetch, execute, writeback and flush signals of the decode stage.
//   slave  : the id_stage side (consumes fetch/wb/flush, produces decoded outputs)
//   master : the surrounding pipeline side
interface id_stage_if #(parameter int XLEN = core_pkg::XLEN);
  logic            if_valid;
  logic [31:0]     if_instr;
  logic [XLEN-1:0] if_pc;
  logic            if_ready;
  logic            id_valid;
  logic            ex_ready;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [XLEN-1:0] imm;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [4:0]      rd;
  logic            rd_we;
  logic [XLEN-1:0] pc;
  logic            illegal;
  logic            wb_we;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            flush;

  modport slave (
    input  if_valid, if_instr, if_pc, ex_ready, wb_we, wb_rd, wb_data, flush,
    output if_ready, id_valid, rs1_data, rs2_data, imm, opcode, funct3, funct7,
           rd, rd_we, pc, illegal
  );

  modport master (
    output if_valid, if_instr, if_pc, ex_ready, wb_we, wb_rd, wb_data, flush,
    input  if_ready, id_valid, rs1_data, rs2_data, imm, opcode, funct3, funct7,
           rd, rd_we, pc, illegal
  );
endinterface

// File: rtl/regfile.sv
// regfile -- NREG x XLEN register file, x0 reads zero.
//   i_clk, i_rst      : clock, synchronous active-high reset (clears all entries)
//   i_ra1/i_ra2       : combinational read addresses, o_rd1/o_rd2 data
//   i_we/i_wa/i_wd    : synchronous write port, writes to x0 dropped
// Macro ID_WB_BYPASS_EN: forward the same-cycle write data to a matching read.
module regfile #(
  parameter int XLEN = 64,
  parameter int NREG = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [4:0]      i_ra1,
  input  logic [4:0]      i_ra2,
  output logic [XLEN-1:0] o_rd1,
  output logic [XLEN-1:0] o_rd2,
  input  logic            i_we,
  input  logic [4:0]      i_wa,
  input  logic [XLEN-1:0] i_wd
);
  logic [XLEN-1:0] r_mem [NREG];
  logic [XLEN-1:0] w_rd1, w_rd2;

  // Entry 0 is only ever reset, so it stays constant zero.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
    end else if (i_we && (i_wa != 5'd0)) begin
      r_mem[i_wa] <= i_wd;
    end
  end

  assign w_rd1 = (i_ra1 == 5'd0) ? '0 : r_mem[i_ra1];
  assign w_rd2 = (i_ra2 == 5'd0) ? '0 : r_mem[i_ra2];

`ifdef ID_WB_BYPASS_EN
  logic w_byp_ok;
  assign w_byp_ok = i_we && (i_wa != 5'd0);
  assign o_rd1 = (w_byp_ok && (i_wa == i_ra1)) ? i_wd : w_rd1;
  assign o_rd2 = (w_byp_ok && (i_wa == i_ra2)) ? i_wd : w_rd2;
`else
  assign o_rd1 = w_rd1;
  assign o_rd2 = w_rd2;
`endif
endmodule

// File: rtl/id_stage.sv
// id_stage -- single-entry decode pipeline register with register-file read.
//   clk, rst : clock, synchronous active-high reset
//   bus      : id_stage_if.slave -- fetch handshake (if_*), execute handshake
//              (id_valid/ex_ready), registered decoded outputs, wb write port, flush
// Macro ID_WB_BYPASS_EN (in regfile): same-cycle writeback-to-read forwarding.
module id_stage
  import core_pkg::*;
#(
  parameter int XLEN = core_pkg::XLEN,
  parameter int NREG = 32
) (
  input  logic        clk,
  input  logic        rst,
  id_stage_if.slave   bus
);
  logic            r_valid;
  dec_t            r_dec;
  logic [XLEN-1:0] r_imm, r_pc, r_rs1, r_rs2;

  dec_t            w_dec;
  logic [XLEN-1:0] w_imm, w_rs1, w_rs2;
  logic            w_if_ready, w_fire_in;

  regfile #(.XLEN(XLEN), .NREG(NREG)) u_rf (
    .i_clk (clk),
    .i_rst (rst),
    .i_ra1 (bus.if_instr[19:15]),
    .i_ra2 (bus.if_instr[24:20]),
    .o_rd1 (w_rs1),
    .o_rd2 (w_rs2),
    .i_we  (bus.wb_we),
    .i_wa  (bus.wb_rd),
    .i_wd  (bus.wb_data)
  );

  assign w_dec = decode(bus.if_instr);
  // Only OP-IMM carries an immediate; everything else presents zero.
  assign w_imm = (bus.if_instr[6:0] == OPC_OP_IMM)
               ? {{(XLEN-12){bus.if_instr[31]}}, bus.if_instr[31:20]} : '0;

  assign w_if_ready = !r_valid || bus.ex_ready;
  assign w_fire_in  = bus.if_valid && w_if_ready;

  // Data registers load only on an accepted fetch, so they hold through stalls
  // and ignore writeback updates to the operands they already captured.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_dec   <= '0;
      r_imm   <= '0;
      r_pc    <= '0;
      r_rs1   <= '0;
      r_rs2   <= '0;
    end else if (bus.flush) begin
      r_valid <= 1'b0;
    end else if (w_fire_in) begin
      r_valid <= 1'b1;
      r_dec   <= w_dec;
      r_imm   <= w_imm;
      r_pc    <= bus.if_pc;
      r_rs1   <= w_rs1;
      r_rs2   <= w_rs2;
    end else if (bus.ex_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign bus.if_ready = w_if_ready;
  assign bus.id_valid = r_valid;
  assign bus.opcode   = r_dec.opcode;
  assign bus.funct3   = r_dec.funct3;
  assign bus.funct7   = r_dec.funct7;
  assign bus.rd       = r_dec.rd;
  assign bus.rd_we    = r_dec.rd_we;
  assign bus.illegal  = r_dec.illegal;
  assign bus.imm      = r_imm;
  assign bus.pc       = r_pc;
  assign bus.rs1_data = r_rs1;
  assign bus.rs2_data = r_rs2;
endmodule

// File: tb/tb_id_stage.sv
module tb_id_stage;
  localparam int XLEN = 64;

  logic clk = 1'b0;
  logic rst;
  int   ncmp = 0;
  int   nerr = 0;

  id_stage_if #(.XLEN(XLEN)) bus ();

  id_stage #(.XLEN(XLEN), .NREG(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_in();
    bus.if_valid = 1'b0;
    bus.if_instr = 32'h0;
    bus.if_pc    = '0;
    bus.ex_ready = 1'b1;
    bus.wb_we    = 1'b0;
    bus.wb_rd    = 5'd0;
    bus.wb_data  = '0;
    bus.flush    = 1'b0;
  endtask

  initial begin
    logic [63:0] exp_byp;
    rst = 1'b1;
    idle_in();
    step(); step();
    rst = 1'b0;
    // reset state
    chk("rst_valid",   bus.id_valid, 0);
    chk("rst_illegal", bus.illegal,  0);
    chk("rst_rdwe",    bus.rd_we,    0);
    chk("rst_opcode",  bus.opcode,   0);
    chk("rst_imm",     bus.imm,      0);
    chk("rst_pc",      bus.pc,       0);
    chk("rst_rs1",     bus.rs1_data, 0);
    chk("rst_ifready", bus.if_ready, 1);

    // preload x1 = 5
    bus.wb_we = 1; bus.wb_rd = 1; bus.wb_data = 64'd5;
    step();
    bus.wb_we = 0;

    // addi x2,x1,-1
    bus.if_valid = 1; bus.if_instr = 32'hFFF08113; bus.if_pc = 64'h100;
    step();
    chk("addi_valid",  bus.id_valid, 1);
    chk("addi_rs1",    bus.rs1_data, 5);
    chk("addi_imm",    bus.imm,      64'hFFFF_FFFF_FFFF_FFFF);
    chk("addi_rd",     bus.rd,       2);
    chk("addi_rdwe",   bus.rd_we,    1);
    chk("addi_ill",    bus.illegal,  0);
    chk("addi_opc",    bus.opcode,   7'h13);
    chk("addi_pc",     bus.pc,       64'h100);

    // stall 3 cycles with add x5,x1,x2 waiting; write x1=9 during stall
    bus.if_instr = 32'h002082B3; bus.if_pc = 64'h104; bus.ex_ready = 0;
    bus.wb_we = 1; bus.wb_rd = 1; bus.wb_data = 64'd9;
    #1;
    chk("stall_ifready", bus.if_ready, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      bus.wb_we = 0;
      chk("stall_valid", bus.id_valid, 1);
      chk("stall_rd",    bus.rd,       2);
      chk("stall_rs1",   bus.rs1_data, 5);
      chk("stall_imm",   bus.imm,      64'hFFFF_FFFF_FFFF_FFFF);
      chk("stall_pc",    bus.pc,       64'h100);
      chk("stall_ifrdy", bus.if_ready, 0);
    end
    bus.ex_ready = 1;
    #1;
    chk("unstall_ifready", bus.if_ready, 1);
    step();
    chk("add_valid", bus.id_valid, 1);
    chk("add_rd",    bus.rd,       5);
    chk("add_opc",   bus.opcode,   7'h33);
    chk("add_imm",   bus.imm,      0);
    chk("add_rdwe",  bus.rd_we,    1);
    chk("add_rs1",   bus.rs1_data, 9);
    chk("add_rs2",   bus.rs2_data, 0);
    chk("add_pc",    bus.pc,       64'h104);

    // drain: ex transfer without fetch transfer
    bus.if_valid = 0;
    step();
    chk("drain_valid", bus.id_valid, 0);

    // bypass: x3=0x11, then write 0xABCD while reading x3 (addi x7,x3,0)
    bus.wb_we = 1; bus.wb_rd = 3; bus.wb_data = 64'h11;
    step();
    bus.wb_data = 64'hABCD;
    bus.if_valid = 1; bus.if_instr = 32'h00018393;
`ifdef ID_WB_BYPASS_EN
    exp_byp = 64'hABCD;
`else
    exp_byp = 64'h11;
`endif
    step();
    chk("byp_rs1", bus.rs1_data, exp_byp);
    chk("byp_rd",  bus.rd,       7);

    // x0: write 0x1234 to x0 alongside addi x0,x0,0, then addi x8,x0,5
    bus.wb_rd = 0; bus.wb_data = 64'h1234; bus.if_instr = 32'h00000013;
    step();
    chk("x0_rs1",  bus.rs1_data, 0);
    chk("x0_rd",   bus.rd,       0);
    chk("x0_rdwe", bus.rd_we,    0);
    bus.wb_we = 0; bus.if_instr = 32'h00500413;
    step();
    chk("x0rd_rs1",  bus.rs1_data, 0);
    chk("x0rd_imm",  bus.imm,      5);
    chk("x0rd_rdwe", bus.rd_we,    1);

    // flush during fetch transfer with coinciding WB write of x10
    bus.wb_we = 1; bus.wb_rd = 10; bus.wb_data = 64'h55;
    bus.if_instr = 32'h00050593; bus.flush = 1;
    #1;
    chk("flush_ifready", bus.if_ready, 1);
    step();
    chk("flush_valid", bus.id_valid, 0);
    bus.flush = 0; bus.wb_we = 0;
    step();
    chk("postflush_valid", bus.id_valid, 1);
    chk("postflush_rs1",   bus.rs1_data, 64'h55);
    chk("postflush_rd",    bus.rd,       11);

    // illegal load opcode, then reset mid-stall
    bus.if_instr = 32'h0000B603;
    step();
    chk("ill_ill",  bus.illegal, 1);
    chk("ill_rdwe", bus.rd_we,   0);
    chk("ill_opc",  bus.opcode,  7'h03);
    chk("ill_f3",   bus.funct3,  3);
    chk("ill_imm",  bus.imm,     0);
    chk("ill_valid", bus.id_valid, 1);
    bus.ex_ready = 0; bus.if_instr = 32'h00A086B3;
    step();
    chk("illstall_ill", bus.illegal, 1);
    rst = 1;
    step();
    rst = 0; bus.if_valid = 0; bus.ex_ready = 1;
    #1;
    chk("r2_valid", bus.id_valid, 0);
    chk("r2_ill",   bus.illegal,  0);
    chk("r2_rdwe",  bus.rd_we,    0);
    chk("r2_opc",   bus.opcode,   0);
    chk("r2_f3",    bus.funct3,   0);
    chk("r2_rd",    bus.rd,       0);
    chk("r2_pc",    bus.pc,       0);
    chk("r2_rs1",   bus.rs1_data, 0);
    // register file cleared: add x13,x1,x10
    bus.if_valid = 1; bus.if_instr = 32'h00A086B3;
    step();
    chk("r2rf_valid", bus.id_valid, 1);
    chk("r2rf_rs1",   bus.rs1_data, 0);
    chk("r2rf_rs2",   bus.rs2_data, 0);
    bus.if_valid = 0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 SHALL have parameter XLEN, 64, datapath width in bits.
REQ-002 SHALL have parameter NREG, 32, architectural register count (x0..x31).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have ports if_valid input 1, if_instr input 32, if_pc input XLEN, if_ready output 1; this is the fetch-side handshake.
REQ-006 SHALL have ports id_valid output 1, ex_ready input 1; this is the execute-side handshake.
REQ-007 SHALL have outputs rs1_data XLEN, rs2_data XLEN, imm XLEN, opcode 7, funct3 3, funct7 7, rd 5, rd_we 1, pc XLEN, illegal 1; all are registered and valid while id_valid=1.
REQ-008 SHALL have ports wb_we input 1, wb_rd input 5, wb_data input XLEN; this is the register-file write port.
REQ-009 SHALL have port flush input 1; it kills the instruction held in ID.

Function
REQ-010 SHALL define the transfer rules: a fetch-side transfer occurs when if_valid&&if_ready; an execute-side transfer occurs when id_valid&&ex_ready.
REQ-011 SHALL compute if_ready = !id_valid || ex_ready, a single-entry pipeline register with no bubble on back-to-back transfers.
REQ-012 SHALL capture decoded fields on a fetch-side transfer: opcode=instr[6:0], rd=instr[11:7], funct3=instr[14:12], funct7=instr[31:25], pc=if_pc; the latency is one cycle.
REQ-013 SHALL read rs1 at address instr[19:15] and rs2 at address instr[24:20] in the cycle of capture; x0 SHALL always read 0.
REQ-014 SHALL set imm as follows: opcode 0010011 gives sign-extend(instr[31:20]) to XLEN; opcode 0110011 gives 0.
REQ-015 SHALL set rd_we=1 for opcodes 0110011 and 0010011 when rd!=0, and rd_we=0 otherwise.
REQ-016 SHALL set illegal=1 and rd_we=0 for any other opcode; the instruction still flows downstream.
REQ-017 SHALL hold all outputs stable while id_valid=1 && ex_ready=0 (stall).
REQ-018 SHALL clear id_valid on the next edge when the execute-side transfer occurs and no fetch-side transfer occurs.
REQ-019 SHALL write wb_data to wb_rd on the edge when wb_we=1; writes to x0 SHALL be discarded.
REQ-020 SHALL give flush priority: on flush=1, id_valid=0 on the next edge and the fetch-side input of that cycle is dropped; if_ready is unaffected combinationally.
REQ-021 SHALL still perform a WB write that coincides with flush.
REQ-022 SHALL, when a WB write and a stall coincide, not update the held rs1_data/rs2_data; holding stale operands is the hazard unit's responsibility.

Reset
REQ-023 SHALL, while rst=1 at an edge, set id_valid=0, illegal=0, rd_we=0, and set opcode, funct3, funct7, rd, imm, pc, rs1_data, rs2_data to 0.
REQ-024 SHALL clear all registers x1..x31 to 0 on reset.
REQ-025 SHALL give rst priority over flush, wb_we and both handshakes; a transfer in flight when reset arrives mid-stall is discarded.

Configuration
REQ-026 SHALL, with ID_WB_BYPASS_EN defined, return wb_data instead of the stored value for an rs1/rs2 read whose address equals wb_rd with wb_we=1 and wb_rd!=0 in the same cycle.
REQ-027 SHALL, without ID_WB_BYPASS_EN, return the pre-write stored value for that read, with no bypass logic.

Structure
REQ-028 SHALL take the opcode constants OPC_OP=0110011 and OPC_OP_IMM=0010011, XLEN and the decoded-instruction struct typedef from shared package core_pkg; the same package is used by execute.
REQ-029 SHALL implement the register file as sub-module regfile (two combinational read ports, one synchronous write port, x0 hardwired to zero); the pipeline register and decode stay in id_stage.

Verification
REQ-030 SHALL cover addi: x1=5 preloaded, instr 0xFFF08113 (addi x2,x1,-1) -> next cycle id_valid=1, rs1_data=5, imm=0xFFFF_FFFF_FFFF_FFFF, rd=2, rd_we=1, illegal=0.
REQ-031 SHALL cover stall: ex_ready=0 for 3 cycles with if_valid=1 -> if_ready=0 and outputs unchanged; ex_ready=1 -> the next instruction is captured on the following edge.
REQ-032 SHALL cover the bypass: wb_we=1, wb_rd=3, wb_data=0xABCD with a read of x3 in the same cycle -> rs1_data=0xABCD with ID_WB_BYPASS_EN, the old value without it.
REQ-033 SHALL cover x0: a write of 0x1234 to x0, then a read of x0 -> rs1_data=0; rd=0 gives rd_we=0.
REQ-034 SHALL cover flush during a fetch-side transfer -> id_valid=0 next cycle; a WB write in the same cycle is still visible afterwards.
REQ-035 SHALL cover opcode 0000011, then rst=1 mid-stall -> illegal=1, rd_we=0; after reset all outputs and the register file read 0.
